// File: rtl/vram_pkg.sv
// Shared VRAM geometry, address packing helper and arbiter state encoding.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package vram_pkg;

  localparam int VRAM_AW  = 11;
  localparam int VRAM_DW  = 8;
  localparam int LAST_ROW = 16;
  localparam int LAST_COL = 59;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Text cell address is {row, col}; column field is 6 bits wide even though only 0..59 is used.
  function automatic logic [VRAM_AW-1:0] pack_addr(input logic [4:0] row, input logic [5:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vram_arbiter_rr_pick.sv
// Round-robin selector: first set request bit at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; grant is one-hot, or zero when no request is set.
module rr_pick
  import vram_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  // Scan offsets 0..N-1 from the pointer; the first hit wins.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (((int'(ptr) + i) % N) == j)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Round-robin arbiter with per-requester lock, sharing one VRAM port among NREQ requesters.
// Latency: accept in cycle N drives VRAM pins in N+1; read data returns in N+1+READ_LAT.
// Backpressure: ready is combinational; non-owners stall while a lock is held, no handover in the release cycle.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = VRAM_AW,
  parameter int DW       = VRAM_DW,
  parameter int READ_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req_valid,
  output logic [NREQ-1:0]    o_req_ready,
  input  logic [NREQ-1:0]    i_req_we,
  input  logic [NREQ-1:0]    i_req_lock,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_wdata,
  output logic [NREQ-1:0]    o_rsp_valid,
  output logic [DW-1:0]      o_rsp_data,
  output logic               o_vram_clk,
  output logic               o_vram_ce,
  output logic               o_vram_wre,
  output logic [AW-1:0]      o_vram_addr,
  output logic [DW-1:0]      o_vram_din,
  input  logic [DW-1:0]      i_vram_dout,
  output logic               o_busy
);

  localparam int PW    = $clog2(NREQ);
  localparam int DEPTH = 1 + READ_LAT;

  arb_state_t      state, state_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [NREQ-1:0] pick;
  logic            accept;
  logic [PW-1:0]   acc_idx;
  logic [DEPTH-1:0] tag_vld;
  logic [PW-1:0]   tag_id [DEPTH];

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req   (i_req_valid),
    .ptr   (ptr),
    .grant (pick)
  );

  // State register: arbitration state, lock owner and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FREE;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next state: pointer advances past every accepted requester; lock enter/release.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    if (accept) begin
      ptr_nxt = (acc_idx == PW'(NREQ - 1)) ? '0 : acc_idx + 1'b1;
    end
    case (state)
      FREE: begin
        if (accept && i_req_lock[acc_idx]) begin
          state_nxt = LOCKED;
          owner_nxt = acc_idx;
        end
      end
      LOCKED: begin
        // Release on an unlocking owner access, or when the owner goes idle without lock.
        if (!i_req_lock[owner] && (accept || !i_req_valid[owner])) begin
          state_nxt = FREE;
        end
      end
      default: state_nxt = FREE;
    endcase
  end

  // Outputs: ready goes to the round-robin winner, or only to the owner while locked.
  always_comb begin
    o_req_ready = '0;
    if (!i_rst) begin
      if (state == FREE) begin
        o_req_ready = pick;
      end else begin
        o_req_ready[owner] = i_req_valid[owner];
      end
    end
  end

  // Encode the one-hot ready into the accepted requester index.
  always_comb begin
    acc_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (o_req_ready[k]) acc_idx = PW'(k);
    end
  end

  assign accept = |o_req_ready;

  // VRAM pins are registered one cycle after accept; addr/din hold between accesses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vram_ce   <= 1'b0;
      o_vram_wre  <= 1'b0;
      o_vram_addr <= '0;
      o_vram_din  <= '0;
    end else begin
      o_vram_ce  <= accept;
      o_vram_wre <= accept & i_req_we[acc_idx];
      if (accept) begin
        o_vram_addr <= i_req_addr[int'(acc_idx)*AW +: AW];
        o_vram_din  <= i_req_wdata[int'(acc_idx)*DW +: DW];
      end
    end
  end

  // Requester-ID tag pipeline; reset drops every read in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_vld <= '0;
      for (int k = 0; k < DEPTH; k++) tag_id[k] <= '0;
    end else begin
      tag_vld[0] <= accept & ~i_req_we[acc_idx];
      tag_id[0]  <= acc_idx;
      for (int k = 1; k < DEPTH; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  // Response strobe comes from the last tag stage, aligned with VRAM read data.
  always_comb begin
    o_rsp_valid = '0;
    if (tag_vld[READ_LAT]) o_rsp_valid[tag_id[READ_LAT]] = 1'b1;
  end

  assign o_rsp_data = i_vram_dout;
  assign o_vram_clk = i_clk;
  assign o_busy     = (state == LOCKED) | (|tag_vld);

endmodule
